// File: rtl/reg_dump.sv
// Debug read-out engine: walks a wrap-around register address range through one read port
// and streams {address, data} beats over valid/ready. Optional trailing XOR beat: REG_DUMP_CHECKSUM_EN.
module reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first,
    input  logic [ADDR_W-1:0] last,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam logic [1:0] CSUM = 2'd3;
`endif

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] ptrNext;
    logic              handshake;
    logic              lastData;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    // Address subtraction wraps naturally in ADDR_W bits, giving the modular span.
    assign span      = last - first;
    assign len       = {1'b0, span} + (ADDR_W+1)'(1);
    assign ptrNext   = (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + ADDR_W'(1);
    assign handshake = out_valid & out_ready;
    assign lastData  = (remaining == '0);
    assign rd_addr   = ptr;
    assign busy      = (state != IDLE);

`ifdef REG_DUMP_CHECKSUM_EN
    assign out_last = (state == CSUM);
`else
    assign out_last = (state == SEND) && lastData;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= first;
                        remaining <= len;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_addr  <= ptr;
                    out_valid <= 1'b1;
                    ptr       <= ptrNext;
                    remaining <= remaining - (ADDR_W+1)'(1);
`ifdef REG_DUMP_CHECKSUM_EN
                    csum      <= '0;
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
`ifdef REG_DUMP_CHECKSUM_EN
                        csum <= csum ^ out_data;
`endif
                        if (!lastData) begin
                            out_data  <= rd_data;
                            out_addr  <= ptr;
                            ptr       <= ptrNext;
                            remaining <= remaining - (ADDR_W+1)'(1);
                        end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                            // Checksum beat folds in the final data beat being accepted now.
                            out_data <= csum ^ out_data;
                            out_addr <= '0;
                            state    <= CSUM;
`else
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
`endif
                        end
                    end
                end
                default: begin
`ifdef REG_DUMP_CHECKSUM_EN
                    if (handshake) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: a reference model queues expected beats at each start,
// and a negedge monitor pops and compares every accepted beat.
module tb_reg_dump;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] first = '0;
    logic [ADDR_W-1:0] last = '0;
    logic [ADDR_W-1:0] rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              outValid;
    logic              outReady = 1'b0;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;
    logic              outLast;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t expQ[$];
    beat_t expBeat;
    beat_t held;
    int    compared = 0;
    int    mismatched = 0;
    int    popCount = 0;
    bit    expectDone = 1'b0;
    bit    prevStall = 1'b0;

    reg_dump #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
        .rd_addr(rdAddr), .rd_data(rdData),
        .out_valid(outValid), .out_ready(outReady), .out_addr(outAddr),
        .out_data(outData), .out_last(outLast), .busy(busy), .done(done)
    );

    assign rdData = regs[rdAddr];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: enumerate the range with modular arithmetic and snapshot current register values.
    function automatic int pushExpected(input int f, input int l);
        int n;
        int a;
        logic [DATA_W-1:0] x;
        beat_t b;
        n = ((l - f + NUM_REGS) % NUM_REGS) + 1;
        x = '0;
        for (int i = 0; i < n; i++) begin
            a = (f + i) % NUM_REGS;
            b.addr = ADDR_W'(a);
            b.data = regs[a];
`ifdef REG_DUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == n - 1);
`endif
            x = x ^ regs[a];
            expQ.push_back(b);
        end
`ifdef REG_DUMP_CHECKSUM_EN
        b.addr = '0;
        b.data = x;
        b.last = 1'b1;
        expQ.push_back(b);
        n = n + 1;
`endif
        return n;
    endfunction

    // Monitor: compares accepted beats against the queue, checks stalled beats stay put, and checks done.
    always @(negedge clk) begin
        if (!rst) begin
            prevStall  = 1'b0;
            expectDone = 1'b0;
        end else begin
            checkOutput("done_pulse", 64'(done), 64'(expectDone));
            expectDone = 1'b0;
            if (prevStall) begin
                checkOutput("hold_valid", 64'(outValid), 64'd1);
                checkOutput("hold_beat", 64'({outAddr, outData, outLast}), 64'(held));
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got addr 0x%0h data 0x%0h, expected no beat", outAddr, outData);
                end else begin
                    expBeat = expQ.pop_front();
                    checkOutput("beat_addr", 64'(outAddr), 64'(expBeat.addr));
                    checkOutput("beat_data", 64'(outData), 64'(expBeat.data));
                    checkOutput("beat_last", 64'(outLast), 64'(expBeat.last));
                    if (expBeat.last) expectDone = 1'b1;
                end
                popCount++;
            end
            prevStall = outValid && !outReady;
            held = {outAddr, outData, outLast};
        end
    end

    // mode: 0 ready always high, 1 ready toggles 1010, 2 random ready, 3 stall on addr 5 and overwrite it
    task automatic applyStimulus(input int f, input int l, input int mode, input bit extraStart);
        int  beats;
        int  cycles;
        int  stall;
        bit  doneSeen;
        bit  snapDone;
        beats    = pushExpected(f, l);
        cycles   = 0;
        stall    = 0;
        doneSeen = 1'b0;
        snapDone = 1'b0;
        first    = ADDR_W'(f);
        last     = ADDR_W'(l);
        start    = 1'b1;
        outReady = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!doneSeen && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
            if (extraStart && cycles == 2) begin
                start = 1'b1;
                first = ADDR_W'(20);
                last  = ADDR_W'(25);
            end
            if (done) begin
                doneSeen = 1'b1;
            end else begin
                case (mode)
                    0: outReady = 1'b1;
                    1: outReady = cycles[0];
                    2: outReady = 1'($urandom_range(0, 1));
                    default: begin
                        if (!snapDone && outValid && outAddr == ADDR_W'(5)) begin
                            outReady = 1'b0;
                            regs[5]  = 32'hDEADBEEF;
                            snapDone = 1'b1;
                            stall    = 4;
                        end else if (stall > 0) begin
                            stall--;
                            outReady = (stall == 0);
                        end else begin
                            outReady = 1'b1;
                        end
                    end
                endcase
            end
        end
        if (!doneSeen) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
        end
        checkOutput("busy_after_done", 64'(busy), 64'd0);
        if (mode == 0) checkOutput("dump_latency", 64'(cycles), 64'(beats + 2));
        @(negedge clk);
        #1;
        checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
        outReady = 1'b0;
        if (extraStart) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                checkOutput("ignored_start_idle", 64'(busy), 64'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetMidDump();
        int beats;
        int cycles;
        beats    = pushExpected(0, 31);
        popCount = 0;
        cycles   = 0;
        first    = '0;
        last     = ADDR_W'(31);
        start    = 1'b1;
        outReady = 1'b1;
        while (popCount < 10 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            start = 1'b0;
        end
        checkOutput("reset_reached_beat10", 64'(popCount >= 10), 64'd1);
        rst = 1'b0;
        #1;
        checkOutput("midreset_valid", 64'(outValid), 64'd0);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_done", 64'(done), 64'd0);
        checkOutput("midreset_last", 64'(outLast), 64'd0);
        checkOutput("midreset_rdaddr", 64'(rdAddr), 64'd0);
        expQ.delete();
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(4, 12, 2, 1'b0);
        if (beats == 0) $display("[TB] empty model range");
    endtask

    initial begin
        int f;
        int l;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 32'h100 + 32'(i);
        #12;
        checkOutput("reset_valid", 64'(outValid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_last", 64'(outLast), 64'd0);
        checkOutput("reset_addr", 64'(outAddr), 64'd0);
        checkOutput("reset_data", 64'(outData), 64'd0);
        checkOutput("reset_rdaddr", 64'(rdAddr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 31, 0, 1'b0);
        applyStimulus(30, 1, 0, 1'b0);
        applyStimulus(0, 31, 1, 1'b0);
        applyStimulus(7, 7, 1, 1'b1);
        applyStimulus(3, 8, 3, 1'b0);
        applyStimulus(5, 5, 0, 1'b0);
        applyStimulus(31, 31, 0, 1'b0);
        applyStimulus(1, 0, 2, 1'b0);
        resetMidDump();

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom;
            f = int'($urandom_range(0, NUM_REGS - 1));
            l = int'($urandom_range(0, NUM_REGS - 1));
            applyStimulus(f, l, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/reg_dump.md
# reg_dump

Debug read-out engine for the datapath register file: on a `start` pulse it walks a contiguous, wrap-around range of register addresses through one register-file read port and streams each `{address, data}` pair out over a valid/ready handshake. It sits between the register file's read port and a debug/trace sink (UART bridge, scan buffer, or testbench monitor). It never writes the register file.

## Interface
- `NUM_REGS`, 32: registers in the file; must equal 2^`ADDR_W`.
- `ADDR_W`, 5: register address width.
- `DATA_W`, 32: register data width.

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin dump; sampled only in IDLE
- `first`  in  ADDR_W  first register address of range, sampled with `start`
- `last`  in  ADDR_W  last register address of range, sampled with `start`
- `rd_addr`  out  ADDR_W  register-file read address, equal to internal pointer `ptr`
- `rd_data`  in  DATA_W  register-file read data, combinational from `rd_addr`
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  sink accepts beat
- `out_addr`  out  ADDR_W  register address of current beat
- `out_data`  out  DATA_W  register value of current beat
- `out_last`  out  1  current beat is the final beat of the dump
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- Beat count `len = ((last - first) mod NUM_REGS) + 1`, held in an `ADDR_W+1`-bit down-counter `remaining`; range 1..32.
- `first > last` wraps: first=30, last=1 yields 30, 31, 0, 1. `first == last` yields exactly one beat.
- `ptr` increments mod `NUM_REGS` (31 -> 0).
- States: IDLE, LOAD, SEND, plus CSUM when the macro is enabled.
  - IDLE: `start`=1 -> `ptr<=first`, `remaining<=len`, go to LOAD. `start` in any other state is ignored.
  - LOAD (one cycle): `out_data<=rd_data`, `out_addr<=ptr`, `out_valid<=1`, `ptr<=ptr+1`, `remaining<=remaining-1`, go to SEND.
  - SEND: hold `out_*` stable while `out_valid & !out_ready`. On handshake with `remaining != 0`: reload `out_data/out_addr` from `rd_data/ptr`, advance `ptr`, decrement `remaining`, stay in SEND with `out_valid` still 1. On handshake with `remaining == 0`: go to CSUM if the macro is enabled; otherwise `out_valid<=0`, pulse `done`, go to IDLE.
- `out_last` = (state SEND and `remaining == 0` and macro disabled) or state CSUM.
- Data is a snapshot of the register taken at the edge its beat is loaded. Later register-file writes do not alter a pending beat.

## Timing
- Reset (async assert): state IDLE; `out_valid`, `out_last`, `busy`, `done` = 0; `out_addr`, `out_data`, `ptr`, `remaining` = 0. This holds even mid-dump; no partial beat survives reset.
- `start` sampled at edge k -> LOAD after edge k, `out_valid`=1 after edge k+1.
- With `out_ready` held high, beats transfer on consecutive cycles with no bubbles: len beats in len cycles.
- `done` is high for exactly the cycle after the final handshake edge. `busy` falls at the same edge.
- `start` may be re-asserted in the cycle `done` is high; it is sampled because the state is already IDLE.

## Configuration
- `REG_DUMP_CHECKSUM_EN` defined: an accumulator XORs `out_data` of every data beat at its handshake (cleared in LOAD-from-IDLE). After the last data beat is accepted, the state moves to CSUM and presents one extra beat with `out_addr=0`, `out_data`=XOR of all data beats, `out_last=1`. When this beat is accepted, `done` pulses and the state returns to IDLE. Total beats = len+1.
- Macro not defined: no accumulator and no CSUM state. `out_last` is set on the final data beat. Total beats = len.

## Test plan
- Full dump: registers preset to r[i]=0x100+i, first=0, last=31, `out_ready`=1 -> 32 beats on consecutive cycles, addr 0..31, data 0x100..0x11F, `out_last` only on addr 31, `done` pulse 1 cycle later. With the macro, a 33rd beat carries data 0x00000000 (the XOR of 0x100..0x11F).
- Wrap range: first=30, last=1 -> beats at addr 30, 31, 0, 1 only.
- Backpressure: `out_ready` toggling 1010… -> each beat is held stable until accepted, no beat is dropped or duplicated, and sequence order is preserved.
- Single beat and ignored start: first=last=7 -> one beat at addr 7 with `out_last`=1. A second `start` pulse while `busy`=1 has no effect.
- Snapshot: r[5] is overwritten with 0xDEADBEEF while the addr-5 beat stalls on `out_ready`=0 -> the beat still shows the old value. A later dump shows 0xDEADBEEF.
- Async reset mid-dump: `rst`=0 at beat 10 of 32 -> `out_valid`, `busy`, `done` go to 0 immediately. After release, a new dump starts cleanly from `first`.
